// File: rtl/mbist_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mbist_pkg: shared types and March C- element tables for the MBIST engine  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package mbist_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [2:0] march_elem_t;

  localparam march_elem_t E0 = 3'd0;
  localparam march_elem_t E1 = 3'd1;
  localparam march_elem_t E2 = 3'd2;
  localparam march_elem_t E3 = 3'd3;
  localparam march_elem_t E4 = 3'd4;
  localparam march_elem_t E5 = 3'd5;

  function automatic logic elem_down(input march_elem_t e);
    return (e == E3) || (e == E4);
  endfunction

  function automatic logic elem_two_ops(input march_elem_t e);
    return (e != E0) && (e != E5);
  endfunction

  // Polarity 1 selects the complemented background.
  function automatic logic elem_rd_pol(input march_elem_t e);
    return (e == E2) || (e == E4);
  endfunction

  function automatic logic elem_wr_pol(input march_elem_t e);
    return (e == E1) || (e == E3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mbist_march_controller_addr_gen.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mbist_addr_gen: loadable up/down address counter with terminal flag       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module mbist_addr_gen #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic r_down;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr   <= '0;
      r_down <= 1'b0;
    end else if (load) begin
      addr   <= load_down ? '1 : '0;
      r_down <= load_down;
    end else if (step) begin
      addr   <= r_down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

  assign last = r_down ? (addr == '0) : (addr == '1);

endmodule
`default_nettype wire

// File: rtl/mbist_march_controller.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mbist_march_controller: March C- BIST engine driving a single-port RAM    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module mbist_march_controller
  import mbist_pkg::*;
#(
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter int                DATA_W  = DATA_W_DEF,
  parameter logic [DATA_W-1:0] DATA_BG = {DATA_W{1'b0}},
  parameter int                CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              bist_active,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  err_count,
  output logic              we,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramin,
  input  logic [DATA_W-1:0] ramout
);

  state_t            r_state;
  march_elem_t       r_elem;
  logic              r_phase;
  logic              r_ops_done;
  logic              r_cmp_valid;
  logic [DATA_W-1:0] r_cmp_exp;
  logic [ADDR_W-1:0] r_cmp_addr;
  march_elem_t       r_cmp_elem;
  logic              r_chk_valid;
  logic [DATA_W-1:0] r_chk_exp;
  logic [ADDR_W-1:0] r_chk_addr;
  march_elem_t       r_chk_elem;

  logic [ADDR_W-1:0] w_gen_addr;
  logic              w_gen_last;
  logic              w_parked, w_issue, w_rewind, w_is_write;
  logic              w_addr_end, w_elem_end, w_miscompare;
  logic              w_gen_load, w_gen_load_down, w_gen_step;
  logic [DATA_W-1:0] w_op_data;
  march_elem_t       w_next_elem;

  // The sequencer is parked on E0/address 0 whenever it is not running, so the
  // cycle that accepts start can already issue the first write.
  assign w_parked        = (r_state == IDLE) || (r_state == DONE);
  assign w_issue         = w_parked ? start : ((r_state == RUN) && !r_ops_done);
  assign w_rewind        = (r_state != RUN) && !w_issue;
  assign w_is_write      = (r_elem == E0) || r_phase;
  assign w_op_data       = (w_is_write ? elem_wr_pol(r_elem) : elem_rd_pol(r_elem))
                           ? ~DATA_BG : DATA_BG;
  assign w_addr_end      = !elem_two_ops(r_elem) || r_phase;
  assign w_elem_end      = w_addr_end && w_gen_last;
  assign w_next_elem     = r_elem + 3'd1;
  assign w_gen_load      = w_rewind || (w_issue && w_elem_end);
  assign w_gen_load_down = !w_rewind && elem_down(w_next_elem);
  assign w_gen_step      = w_issue && w_addr_end && !w_gen_last;
  assign w_miscompare    = r_chk_valid && (ramout != r_chk_exp);

  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (w_gen_load),
    .load_down (w_gen_load_down),
    .step      (w_gen_step),
    .addr      (w_gen_addr),
    .last      (w_gen_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_elem      <= E0;
      r_phase     <= 1'b0;
      r_ops_done  <= 1'b0;
      bist_active <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      fail_addr   <= '0;
      fail_elem   <= '0;
      fail_data   <= '0;
      err_count   <= '0;
      we          <= 1'b0;
      ramaddr     <= '0;
      ramin       <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_exp   <= '0;
      r_cmp_addr  <= '0;
      r_cmp_elem  <= E0;
      r_chk_valid <= 1'b0;
      r_chk_exp   <= '0;
      r_chk_addr  <= '0;
      r_chk_elem  <= E0;
    end else begin
      if (w_rewind) begin
        r_elem     <= E0;
        r_phase    <= 1'b0;
        r_ops_done <= 1'b0;
      end else if (w_issue) begin
        if (!w_addr_end) begin
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          if (w_gen_last) begin
            if (r_elem == E5) r_ops_done <= 1'b1;
            else              r_elem     <= w_next_elem;
          end
        end
      end

      we <= w_issue && w_is_write;
      if (w_issue)               ramaddr <= w_gen_addr;
      if (w_issue && w_is_write) ramin   <= w_op_data;

      // Stage 1 rides with the RAM address; stage 2 lines up with ramout.
      r_cmp_valid <= w_issue && !w_is_write;
      r_cmp_exp   <= w_op_data;
      r_cmp_addr  <= w_gen_addr;
      r_cmp_elem  <= r_elem;
      r_chk_valid <= r_cmp_valid;
      r_chk_exp   <= r_cmp_exp;
      r_chk_addr  <= r_cmp_addr;
      r_chk_elem  <= r_cmp_elem;

      if (w_miscompare) begin
        fail <= 1'b1;
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
        if (!fail) begin
          fail_addr <= r_chk_addr;
          fail_elem <= r_chk_elem;
          fail_data <= ramout;
        end
      end

      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state     <= RUN;
            bist_active <= 1'b1;
            done        <= 1'b0;
            fail        <= 1'b0;
            fail_addr   <= '0;
            fail_elem   <= '0;
            fail_data   <= '0;
            err_count   <= '0;
          end
        end
        RUN: begin
          if (r_ops_done) r_state <= DRAIN;
        end
        DRAIN: begin
          r_state     <= DONE;
          bist_active <= 1'b0;
          done        <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
